fir_tdm_scheduler: RTL
======================

Name: fir_tdm_scheduler

Overview:
Time-multiplexed FIR controller that shares one 16x16 multiply-accumulate unit across NCH independent audio channels, e.g. L/R or synth voices.
- Accepts one sample per handshake and keeps a per-channel circular history.
- Runs NTAPS MAC cycles against a runtime-writable coefficient bank, then delivers one filtered sample per request through a valid/ready handshake.
- Sits between the oversampled voice mixer and the decimator, and replaces per-channel parallel FIR instances.

Parameters:
NTAPS, 16, number of filter taps (power of two, 4..64)
NCH, 2, number of channels sharing the MAC (power of two, 1..8)
SHIFT, 8, arithmetic right shift applied to the accumulator before output

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input sample offered
in_ready  out  1  block can accept a sample
in_ch  in  $clog2(NCH) (min 1)  channel of offered sample
in_sample  in  16 signed  input sample
out_valid  out  1  filtered sample available
out_ready  in  1  downstream accepts output
out_ch  out  $clog2(NCH) (min 1)  channel of output sample
out_sample  out  16 signed  filtered sample
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NTAPS)  tap index
coef_wdata  in  16 signed  coefficient value
coef_err  out  1  one-cycle pulse: coefficient write rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_ch=0, out_sample=0, coef_err=0, busy=1.
  - Coefficients load the package default LPF set; all write pointers are 0.
- FSM states: CLEAR -> IDLE -> MAC -> OUT -> IDLE.
- CLEAR, entered from reset:
  - Zeroes all NCH*NTAPS history entries, one per cycle.
  - Moves to IDLE after exactly NCH*NTAPS cycles.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: write in_sample to hist[in_ch][wptr[in_ch]], latch ch, clear acc, set tap=0, go to MAC.
  - wptr[ch] increments modulo NTAPS only after the sample is consumed, on MAC exit.
- MAC, exactly NTAPS cycles:
  - acc += hist[ch][(wptr[ch]-tap) mod NTAPS] * coef[tap], with tap running 0..NTAPS-1.
  - coef[0] therefore multiplies the newest sample; the index wraps modulo NTAPS.
  - Product width is 32 signed; acc width is 32+$clog2(NTAPS) signed and never overflows internally.
- OUT:
  - out_valid=1 with out_sample = (acc >>> SHIFT) reduced to 16 bits (see Optional Feature), out_ch=ch.
  - Held stable until out_valid&&out_ready; that same cycle returns to IDLE.
  - Backpressure holds in_ready=0.
- Latency: from the accept cycle, out_valid rises NTAPS+1 cycles later. Throughput is one sample per NTAPS+2 cycles when out_ready=1.
- Coefficient writes:
  - Honoured only in IDLE (same cycle as an input accept is allowed; the new value is used by that computation).
  - coef_we in any other state is ignored and coef_err pulses for one cycle.
- Input fields are sampled only on the accept cycle. An in_ch value >= NCH (non-power-of-two illegal, so unreachable) needs no handling.
- rst mid-operation: aborts immediately, drops any pending output without out_valid, and re-enters CLEAR. Histories and coefficients return to reset values.

Optional Feature:
FIR_TDM_SAT_EN
- Defined: acc>>>SHIFT is clamped to [-32768, 32767].
- Undefined: the low 16 bits are taken (two's-complement wrap).
- No other behaviour differs.

Decomposition:
- Package fir_pkg holds:
  - sample_t (16-bit signed) and coef_t (16-bit signed)
  - the default 16-tap LPF coefficient array:
    -79,-136,312,654,-1244,-2280,4501,14655,14655,4501,-2280,-1244,654,312,-136,-79
  - the FSM state enum
- One sub-module, fir_mac_unit: registered signed multiply-accumulate with clr/en inputs and a parameterised accumulator width.
- The FSM, histories and coefficient bank live in fir_tdm_scheduler.

Test Plan:
- Impulse: after CLEAR, send ch0 256 then fifteen 0s, out_ready=1.
  - Outputs are -79,-136,312,654,-1244,-2280,4501,14655,14655,... (default coefficients echoed).
  - Each out_valid comes 17 cycles after its accept.
- Channel isolation: interleave an impulse of 256 on ch1 with 0s on ch0.
  - Every ch0 output is 0; ch1 outputs follow the coefficient sequence.
  - out_ch matches the input channel each time.
- Saturation: write all coefs 32767, feed 32767 repeatedly on ch0.
  - Steady output is 32767 with FIR_TDM_SAT_EN.
  - Without it, output is the wrapped low 16 bits of (NTAPS*32767*32767)>>>8.
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_sample and out_ch stay stable, in_ready stays 0.
  - Exactly one transfer occurs on release, then in_ready=1 the next cycle.
- Config guard: coef_we during MAC with addr 0, data 1000.
  - coef_err pulses once; a subsequent impulse still outputs -79 first.
- Reset mid-MAC: assert rst in MAC cycle 5.
  - No out_valid appears; in_ready stays 0 for 32 cycles (NCH*NTAPS).
  - A following impulse reproduces the clean -79 sequence.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types, the FSM state encoding and the default low-pass coefficient set
// for the time-multiplexed FIR scheduler.
package fir_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned PROD_W     = 32;
    localparam int unsigned DEF_TAPS   = 16;
    localparam int unsigned DEF_TAPS_W = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Symmetric 16-tap low-pass, loaded into the coefficient bank at reset
    localparam coef_t DEFAULT_LPF [DEF_TAPS] = '{
        -16'sd79,   -16'sd136,  16'sd312,   16'sd654,
        -16'sd1244, -16'sd2280, 16'sd4501,  16'sd14655,
        16'sd14655, 16'sd4501,  -16'sd2280, -16'sd1244,
        16'sd654,   16'sd312,   -16'sd136,  -16'sd79
    };

    // Default value for tap idx; taps beyond the stored set reset to zero
    function automatic coef_t default_coef(input int unsigned idx);
        logic [DEF_TAPS_W-1:0] sel;
        sel = DEF_TAPS_W'(idx);
        if (idx < DEF_TAPS) begin
            return DEFAULT_LPF[sel];
        end
        return '0;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed 16x16 multiply-accumulate. clr_i zeroes the accumulator,
// en_i adds one product; acc_sum_c exposes the value the next enabled edge stores.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int unsigned ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  sample_t                 a_i,
    input  coef_t                   b_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic signed [ACC_W-1:0] acc_sum_c
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Full-precision product and next accumulator value
    always_comb begin
        prod      = PROD_W'(a_i) * PROD_W'(b_i);
        acc_sum_c = acc_q + ACC_W'(prod);
        acc_d     = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_sum_c;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Time-multiplexed FIR controller: NCH channels share one MAC. Each accepted
// sample runs NTAPS MAC cycles against the coefficient bank and yields one
// filtered sample through a valid/ready handshake.
// Optional build macro FIR_TDM_SAT_EN: clamp the shifted accumulator to 16 bits
// instead of keeping the wrapped low 16 bits.
module fir_tdm_scheduler
    import fir_pkg::*;
#(
    parameter  int unsigned NTAPS = 16,
    parameter  int unsigned NCH   = 2,
    parameter  int unsigned SHIFT = 8,
    localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned TW    = $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  sample_t        in_sample,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output sample_t        out_sample,
    input  logic           coef_we,
    input  logic [TW-1:0]  coef_addr,
    input  coef_t          coef_wdata,
    output logic           coef_err,
    output logic           busy
);

    localparam int unsigned ACC_W  = PROD_W + TW;
    localparam int unsigned HW     = CHW + TW;
    localparam int unsigned HDEPTH = NCH * NTAPS;

`ifdef FIR_TDM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd32768);
`endif

    // Scale the accumulator down and fit it into a 16-bit sample
    function automatic sample_t reduce_acc(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> SHIFT;
`ifdef FIR_TDM_SAT_EN
        if (sh > SAT_HI) begin
            return 16'sh7fff;
        end
        if (sh < SAT_LO) begin
            return 16'sh8000;
        end
        return SAMPLE_W'(sh);
`else
        return SAMPLE_W'(sh);
`endif
    endfunction

    state_e         state_q, state_d;
    logic [HW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [TW-1:0]  tap_q, tap_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [TW-1:0]  wptr_q [NCH];
    sample_t        hist_q [HDEPTH];
    coef_t          coef_q [NTAPS];

    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    sample_t        out_sample_q, out_sample_d;
    logic           coef_err_q, coef_err_d;
    logic           busy_q, busy_d;

    logic           mac_clr;
    logic           mac_en;
    logic           wptr_inc;
    logic           coef_wr;
    logic           hist_we;
    logic [HW-1:0]  hist_waddr;
    sample_t        hist_wdata;
    logic [TW-1:0]  rd_ptr;
    sample_t        mac_a;
    coef_t          mac_b;

    logic signed [ACC_W-1:0] mac_acc;
    logic signed [ACC_W-1:0] mac_sum_c;

    // Operand fetch: newest sample pairs with coef[0], older samples wrap modulo NTAPS
    always_comb begin
        rd_ptr = wptr_q[ch_q] - tap_q;
        mac_a  = hist_q[{ch_q, rd_ptr}];
        mac_b  = coef_q[tap_q];
    end

    // Next-state and control decode
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        tap_d        = tap_q;
        ch_d         = ch_q;
        out_valid_d  = out_valid_q;
        out_ch_d     = out_ch_q;
        out_sample_d = out_sample_q;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        wptr_inc     = 1'b0;
        coef_wr      = 1'b0;
        hist_we      = 1'b0;
        hist_waddr   = clr_cnt_q;
        hist_wdata   = '0;
        coef_err_d   = coef_we && (state_q != ST_IDLE);

        unique case (state_q)
            ST_CLEAR: begin
                hist_we    = 1'b1;
                hist_waddr = clr_cnt_q;
                hist_wdata = '0;
                clr_cnt_d  = clr_cnt_q + HW'(1);
                if (clr_cnt_q == HW'(HDEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                coef_wr = coef_we;
                if (in_valid) begin
                    hist_we    = 1'b1;
                    hist_waddr = {in_ch, wptr_q[in_ch]};
                    hist_wdata = in_sample;
                    ch_d       = in_ch;
                    tap_d      = '0;
                    mac_clr    = 1'b1;
                    state_d    = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                tap_d  = tap_q + TW'(1);
                if (tap_q == TW'(NTAPS - 1)) begin
                    wptr_inc     = 1'b1;
                    out_valid_d  = 1'b1;
                    out_ch_d     = ch_q;
                    out_sample_d = reduce_acc(mac_sum_c);
                    state_d      = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // FSM, sequencing and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            tap_q        <= '0;
            ch_q         <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
            coef_err_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            tap_q        <= tap_d;
            ch_q         <= ch_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
            coef_err_q   <= coef_err_d;
            busy_q       <= busy_d;
        end
    end

    // Per-channel write pointers advance once the sample has been consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
            end
        end else if (wptr_inc) begin
            wptr_q[ch_q] <= wptr_q[ch_q] + TW'(1);
        end
    end

    // Coefficient bank: defaults at reset, runtime writes only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                coef_q[i] <= default_coef(i);
            end
        end else if (coef_wr) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    // History storage; zeroed by the CLEAR sweep rather than by reset
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_q[hist_waddr] <= hist_wdata;
        end
    end

    fir_mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (mac_clr),
        .en_i      (mac_en),
        .a_i       (mac_a),
        .b_i       (mac_b),
        .acc_o     (mac_acc),
        .acc_sum_c (mac_sum_c)
    );

    // Final value is captured from acc_sum_c; the registered copy is not needed here
    logic unused_acc;
    assign unused_acc = ^mac_acc;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign coef_err   = coef_err_q;
    assign busy       = busy_q;

endmodule
